lock_top: RTL and testbench
===========================

// Module: lock_top
// PURPOSE
//  Two-button combination lock. Serial 0/1 presses on btn_0/btn_1 are entered
//  as a fixed-length code and compared with CODE; a match pulses unlock for a
//  set time. Top-level block: raw button pins in, unlock drive out.
//  Includes input synchronisation, press detection, inter-press timeout and
//  lockout after repeated wrong codes.
// PARAMETERS
//  CODE_LEN       4        number of presses per attempt (1..16)
//  CODE           4'b1101  secret code; MSB = first press, 1 = btn_1, 0 = btn_0
//  UNLOCK_CYCLES  50       clock cycles unlock stays high after a match
//  TIMEOUT_CYCLES 1000     idle cycles mid-entry before partial code is discarded
//  MAX_FAILS      3        consecutive wrong attempts that trigger lockout
//  LOCKOUT_CYCLES 500      cycles all presses are ignored during lockout
// PORTS
//  clk        in   1  system clock, all logic on rising edge
//  btn_reset  in   1  reset: synchronous, active-high
//  btn_0      in   1  raw "0" button, asynchronous, active-high
//  btn_1      in   1  raw "1" button, asynchronous, active-high
//  unlock     out  1  registered; high while lock is open
// BEHAVIOUR
//  Reset (btn_reset high at a clk edge, overrides everything):
//   state=IDLE, unlock=0, entry count=0, shift reg=0, fail count=0, timers=0,
//   synchroniser/edge-detect flops=0. Reset asserted mid-entry/OPEN/LOCKOUT
//   drops to IDLE with unlock=0 on that same edge.
//  Input conditioning: each button goes through a 2-flop synchroniser plus a
//   third flop; press0/press1 = sync2 & ~sync3 (one-cycle pulse per rising edge).
//   A held button counts once. press0 & press1 in the same cycle: ignored.
//  Latency: final press sampled high at edge t -> press pulse evaluated at
//   edge t+2 -> unlock=1 visible after edge t+2.
//  States:
//   IDLE:    valid press -> shift bit in, count=1, ENTRY.
//   ENTRY:   valid press -> shift bit in, count++. When count reaches CODE_LEN,
//            compare {shift} with CODE:
//              match    -> OPEN, unlock=1, fail count=0, timer=UNLOCK_CYCLES.
//              mismatch -> fail count++; if it reaches MAX_FAILS -> LOCKOUT,
//                          timer=LOCKOUT_CYCLES, fail count=0; else -> IDLE.
//            No press for TIMEOUT_CYCLES consecutive cycles -> IDLE, entry
//            discarded (not counted as a failure).
//   OPEN:    unlock=1; timer decrements each cycle; at 0 -> IDLE, unlock=0.
//            Presses during OPEN are ignored (no new entry started).
//   LOCKOUT: unlock=0; presses ignored; timer decrements; at 0 -> IDLE.
//  Attempts are fixed-length blocks, not a sliding window: after a wrong
//   CODE_LEN-press attempt the next press begins a fresh attempt.
//  Fail count resets only on success, on lockout entry, or on btn_reset.
//  Counter widths sized by $clog2 of their max values; no wrap-around.
//  unlock is never high outside OPEN.
// TESTING
//  1 Reset: btn_reset=1 for 1 cycle -> unlock=0, state IDLE.
//  2 Correct code 1,1,0,1 (10 ns pulses, 100 ns gaps, 10 ns clk) -> unlock=1
//    two edges after last press sampled, high for exactly 50 cycles, then 0.
//  3 Wrong code 1,1,1,1 then 0 -> unlock stays 0; the 0 starts a new attempt
//    (count=1); following 1,0,1 completes it as wrong (fail count=2).
//  4 Three wrong attempts -> LOCKOUT; correct code during next 500 cycles
//    -> unlock stays 0; correct code after lockout ends -> unlock=1.
//  5 Press 1,1 then idle 1000 cycles, then 0,1 -> no unlock (entry discarded);
//    then full 1,1,0,1 -> unlock=1.
//  6 btn_0 and btn_1 rising same cycle -> ignored; btn_reset during OPEN
//    -> unlock=0 on that edge.

Source files
------------

// File: rtl/lock_top.sv
// Two-button combination lock: synchronised press detection, fixed-length
// code entry, inter-press timeout, timed unlock and lockout after repeated misses.
module lock_top #(
    parameter int CODE_LEN = 4,
    parameter logic [CODE_LEN-1:0] CODE = 4'b1101,
    parameter int UNLOCK_CYCLES = 50,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int MAX_FAILS = 3,
    parameter int LOCKOUT_CYCLES = 500
) (
    input  logic clk,
    input  logic btn_reset,
    input  logic btn_0,
    input  logic btn_1,
    output logic unlock
);

    typedef enum logic [1:0] {IDLE, ENTRY, OPEN, LOCKOUT} state_t;

    localparam int TMAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ?
                          UNLOCK_CYCLES : LOCKOUT_CYCLES;
    localparam int CW = $clog2(CODE_LEN + 1);
    localparam int TW = $clog2(TMAX + 1);
    localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int FW = $clog2(MAX_FAILS + 1);

    localparam logic [CW-1:0] LEN_C = CW'(CODE_LEN);
    localparam logic [TW-1:0] UNL_C = TW'(UNLOCK_CYCLES);
    localparam logic [TW-1:0] LCK_C = TW'(LOCKOUT_CYCLES);
    localparam logic [IW-1:0] TO_C = IW'(TIMEOUT_CYCLES - 1);
    localparam logic [FW-1:0] MF_C = FW'(MAX_FAILS - 1);

    state_t state;
    logic [2:0] sync0;
    logic [2:0] sync1;
    logic [CODE_LEN-1:0] shift;
    logic [CW-1:0] cnt;
    logic [TW-1:0] timer;
    logic [IW-1:0] idle;
    logic [FW-1:0] fails;

    logic press0;
    logic press1;
    logic valid;
    logic [CODE_LEN-1:0] shift_nx;
    logic [CW-1:0] cnt_nx;

    always_comb begin
        press0 = sync0[1] & ~sync0[2];
        press1 = sync1[1] & ~sync1[2];
        valid = press0 ^ press1;
        shift_nx = CODE_LEN'({shift, press1});
        cnt_nx = cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (btn_reset) begin
            state <= IDLE;
            unlock <= 1'b0;
            sync0 <= '0;
            sync1 <= '0;
            shift <= '0;
            cnt <= '0;
            timer <= '0;
            idle <= '0;
            fails <= '0;
        end else begin
            sync0 <= {sync0[1:0], btn_0};
            sync1 <= {sync1[1:0], btn_1};
            unique case (state)
                IDLE, ENTRY: begin
                    if (valid) begin
                        idle <= '0;
                        if (cnt_nx == LEN_C) begin
                            cnt <= '0;
                            shift <= '0;
                            if (shift_nx == CODE) begin
                                state <= OPEN;
                                unlock <= 1'b1;
                                fails <= '0;
                                timer <= UNL_C;
                            end else if (fails == MF_C) begin
                                state <= LOCKOUT;
                                timer <= LCK_C;
                                fails <= '0;
                            end else begin
                                state <= IDLE;
                                fails <= fails + 1'b1;
                            end
                        end else begin
                            state <= ENTRY;
                            cnt <= cnt_nx;
                            shift <= shift_nx;
                        end
                    end else if (state == ENTRY) begin
                        // abandoned partial entry is dropped, not a failure
                        if (idle == TO_C) begin
                            state <= IDLE;
                            cnt <= '0;
                            shift <= '0;
                            idle <= '0;
                        end else begin
                            idle <= idle + 1'b1;
                        end
                    end
                end
                OPEN: begin
                    if (timer <= TW'(1)) begin
                        state <= IDLE;
                        unlock <= 1'b0;
                        timer <= '0;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                LOCKOUT: begin
                    if (timer <= TW'(1)) begin
                        state <= IDLE;
                        timer <= '0;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    unlock <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lock_top.sv
// Bench for lock_top: table of code attempts with a scoreboard of expected
// unlock results, plus directed lockout, timeout, collision and reset cases.
module tb_lock_top;

    logic clk;
    logic btn_reset;
    logic btn_0;
    logic btn_1;
    logic unlock;

    int tests;
    int fails;
    logic exp_q[$];

    typedef struct {
        logic [3:0] code;
        logic exp;
    } vec_t;

    vec_t vecs[6];

    lock_top dut (
        .clk(clk),
        .btn_reset(btn_reset),
        .btn_0(btn_0),
        .btn_1(btn_1),
        .unlock(unlock)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: unlock=%b expected %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic press(input logic b);
        @(negedge clk);
        if (b) btn_1 = 1'b1;
        else btn_0 = 1'b1;
        @(negedge clk);
        btn_0 = 1'b0;
        btn_1 = 1'b0;
    endtask

    task automatic gap(input int n);
        repeat (n) @(negedge clk);
    endtask

    // presses code MSB first; returns right after the last release
    task automatic enter(input logic [3:0] code, input logic exp);
        for (int i = 3; i >= 0; i--) begin
            press(code[i]);
            if (i != 0) gap(10);
        end
        exp_q.push_back(exp);
    endtask

    task automatic sample(input string name);
        logic e;
        @(negedge clk);
        check({name, "_early"}, unlock, 1'b0);
        @(negedge clk);
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = exp_q.pop_front();
            check(name, unlock, e);
        end
    endtask

    task automatic width(input string name);
        int n;
        n = 0;
        while (unlock && n < 100) begin
            n++;
            @(negedge clk);
        end
        check_int(name, n, 50);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        btn_reset = 1'b1;
        btn_0 = 1'b0;
        btn_1 = 1'b0;

        vecs[0] = '{4'b1101, 1'b1};
        vecs[1] = '{4'b1111, 1'b0};
        vecs[2] = '{4'b0101, 1'b0};
        vecs[3] = '{4'b1101, 1'b1};
        vecs[4] = '{4'b1000, 1'b0};
        vecs[5] = '{4'b1101, 1'b1};

        @(posedge clk);
        #1;
        check("reset", unlock, 1'b0);
        @(negedge clk);
        btn_reset = 1'b0;
        gap(5);

        for (int v = 0; v < 6; v++) begin
            enter(vecs[v].code, vecs[v].exp);
            sample($sformatf("vec%0d", v));
            if (vecs[v].exp) width($sformatf("vec%0d_width", v));
            gap(70);
        end

        @(negedge clk);
        btn_0 = 1'b1;
        btn_1 = 1'b1;
        @(negedge clk);
        btn_0 = 1'b0;
        btn_1 = 1'b0;
        gap(10);
        enter(4'b1101, 1'b1);
        sample("both_ignored");
        gap(70);

        for (int k = 0; k < 3; k++) begin
            enter(4'b0000, 1'b0);
            sample($sformatf("wrong%0d", k));
            gap(10);
        end
        enter(4'b1101, 1'b0);
        sample("in_lockout");
        gap(520);
        enter(4'b1101, 1'b1);
        sample("after_lockout");
        gap(70);

        press(1'b1);
        gap(10);
        press(1'b1);
        gap(1010);
        press(1'b0);
        gap(10);
        press(1'b1);
        exp_q.push_back(1'b0);
        sample("timeout_discard");
        gap(1010);
        enter(4'b1101, 1'b1);
        sample("after_timeout");
        gap(70);

        enter(4'b1101, 1'b1);
        sample("open_pre_reset");
        gap(10);
        btn_reset = 1'b1;
        @(posedge clk);
        #1;
        check("reset_in_open", unlock, 1'b0);
        @(negedge clk);
        btn_reset = 1'b0;
        gap(5);
        check("after_reset", unlock, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
